// File: rtl/mul_div_unit.sv
// Iterative 16-bit unsigned multiply/divide unit that stalls the core while it iterates
// and hands the result back through a one-cycle registered write-back port.
module mul_div_unit #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  stall,
  output logic                  busy,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      acc_q, acc_d;
  logic                    busy_q, busy_d;
  logic                    wb_en_q, wb_en_d;
  logic [REG_ADDR_W-1:0]   wb_reg_q, wb_reg_d;
  logic [WIDTH-1:0]        wb_data_q, wb_data_d;
  logic                    dz_q, dz_d;
  logic                    stall_s;

  // Accumulator holds {partial product high, multiplier being consumed from the LSB}.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   a);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // Accumulator holds {remainder, dividend bits shifting out / quotient bits shifting in}.
  // With a zero divisor every trial succeeds, giving an all-ones quotient and remainder = a.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   b);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, b};
    if (shifted >= {1'b0, b}) begin
      return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  endfunction

  function automatic logic [WIDTH-1:0] pick_result(input logic [1:0]         sel,
                                                   input logic [2*WIDTH-1:0] acc);
    case (sel)
      2'b00:   return acc[WIDTH-1:0];
      2'b01:   return acc[2*WIDTH-1:WIDTH];
      2'b10:   return acc[WIDTH-1:0];
      2'b11:   return acc[2*WIDTH-1:WIDTH];
      default: return {WIDTH{1'b0}};
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wb_en_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    dz_d      = 1'b0;
    stall_s   = 1'b0;
    case (state_q)
      IDLE: begin
        stall_s = start;
        if (start) begin
          op_d    = op;
          a_d     = operand_a;
          b_d     = operand_b;
          dest_d  = dest_reg;
          cnt_d   = {CNT_W{1'b0}};
          acc_d   = op[1] ? {{WIDTH{1'b0}}, operand_a} : {{WIDTH{1'b0}}, operand_b};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        stall_s = 1'b1;
        acc_d   = op_q[1] ? div_step(acc_q, b_q) : mul_step(acc_q, a_q);
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d   = DONE;
          wb_en_d   = 1'b1;
          wb_reg_d  = dest_q;
          wb_data_d = pick_result(op_q, acc_d);
          dz_d      = op_q[1] && (b_q == {WIDTH{1'b0}});
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        // The start still visible here belongs to the retiring instruction.
        stall_s = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stall_s = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign stall       = reset ? 1'b0 : stall_s;
  assign busy        = busy_q;
  assign wb_en       = wb_en_q;
  assign wb_reg      = wb_reg_q;
  assign wb_data     = wb_data_q;
  assign div_by_zero = dz_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      dest_q    <= {REG_ADDR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= {REG_ADDR_W{1'b0}};
      wb_data_q <= {WIDTH{1'b0}};
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: cycle-level behavioural model compared every cycle,
// plus directed literal expectations and randomized operations.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [3:0]  dest_reg;
  logic        stall;
  logic        busy;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(16), .REG_ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .stall(stall), .busy(busy), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (o)
      2'd0:    return p[15:0];
      2'd1:    return p[31:16];
      2'd2:    return (b == 16'd0) ? 16'hFFFF : a / b;
      default: return (b == 16'd0) ? a : a % b;
    endcase
  endfunction

  // Model: k = edges since the start was accepted (-1 idle, 0..15 running, 16 write-back cycle)
  int          k = -1;
  bit          m_valid = 1'b0;
  logic [15:0] m_res;
  logic [3:0]  m_dst;
  logic        m_dz;
  logic [15:0] m_last_data;
  logic [3:0]  m_last_reg;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("stall", {31'd0, stall}, reset ? 32'd0 : (k < 0 ? {31'd0, start} : (k < 16 ? 32'd1 : 32'd0)));
      chk("busy", {31'd0, busy}, (k >= 0) ? 32'd1 : 32'd0);
      chk("wb_en", {31'd0, wb_en}, (k == 16) ? 32'd1 : 32'd0);
      chk("wb_reg", {28'd0, wb_reg}, {28'd0, m_last_reg});
      chk("wb_data", {16'd0, wb_data}, {16'd0, m_last_data});
      chk("div_by_zero", {31'd0, div_by_zero}, (k == 16) ? {31'd0, m_dz} : 32'd0);
    end
    if (reset) begin
      m_valid     = 1'b1;
      k           = -1;
      m_last_data = 16'd0;
      m_last_reg  = 4'd0;
    end else if (m_valid) begin
      if (k < 0) begin
        if (start) begin
          k     = 0;
          m_res = ref_result(op, operand_a, operand_b);
          m_dst = dest_reg;
          m_dz  = op[1] && (operand_b == 16'd0);
        end
      end else if (k < 15) begin
        k++;
      end else if (k == 15) begin
        k           = 16;
        m_last_reg  = m_dst;
        m_last_data = m_res;
      end else begin
        k = -1;
      end
    end
  end

  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    op        = r[1:0];
    dest_reg  = r[5:2];
    operand_a = r[31:16];
    r = $urandom;
    operand_b = r[15:0];
  endtask

  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input bit scr,
                        output logic [15:0] rd, output logic rz, output logic [3:0] rr);
    int lat;
    bit found;
    @(posedge clk); #1;
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
    lat = 0; found = 1'b0; rd = 16'd0; rz = 1'b0; rr = 4'd0;
    while (!found && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (wb_en === 1'b1) begin
        found = 1'b1;
        rd = wb_data; rz = div_by_zero; rr = wb_reg;
      end
      if (scr) scramble();
    end
    chk("latency", 32'(lat), 32'd17);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    logic        rz;
    logic [3:0]  rr;
    logic [31:0] r;
    logic [15:0] a, b;

    reset = 1'b1; start = 1'b0; op = 2'd0; operand_a = 16'd0; operand_b = 16'd0; dest_reg = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_reg", {28'd0, wb_reg}, 32'd0);
    chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;

    run_op(2'd0, 16'h0012, 16'h0034, 4'd5, 1'b0, rd, rz, rr);
    chk("mul_data", {16'd0, rd}, 32'h03A8);
    chk("mul_reg", {28'd0, rr}, 32'd5);
    chk("mul_dz", {31'd0, rz}, 32'd0);
    run_op(2'd0, 16'hFFFF, 16'hFFFF, 4'd1, 1'b0, rd, rz, rr);
    chk("mul_ffff", {15'd0, rz, rd}, 32'h0001);
    run_op(2'd1, 16'hFFFF, 16'hFFFF, 4'd0, 1'b0, rd, rz, rr);
    chk("mulh_ffff", {15'd0, rz, rd}, 32'hFFFE);
    chk("mulh_reg0", {28'd0, rr}, 32'd0);
    run_op(2'd2, 16'h0064, 16'h0007, 4'd3, 1'b0, rd, rz, rr);
    chk("div_100_7", {15'd0, rz, rd}, 32'h000E);
    run_op(2'd3, 16'h0064, 16'h0007, 4'd4, 1'b0, rd, rz, rr);
    chk("rem_100_7", {15'd0, rz, rd}, 32'h0002);
    run_op(2'd2, 16'h1234, 16'h0000, 4'd6, 1'b0, rd, rz, rr);
    chk("div_by0", {15'd0, rz, rd}, 32'h1FFFF);
    run_op(2'd3, 16'h1234, 16'h0000, 4'd6, 1'b0, rd, rz, rr);
    chk("rem_by0", {15'd0, rz, rd}, 32'h11234);

    run_op(2'd0, 16'h0101, 16'h0003, 4'd7, 1'b1, rd, rz, rr);
    chk("scr_data", {16'd0, rd}, 32'h0303);
    chk("scr_reg", {28'd0, rr}, 32'd7);
    chk("scr_no_relaunch", {31'd0, busy}, 32'd0);

    // Abort mid-run: reset lands on the edge after iteration 8.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd0; operand_a = 16'd5; operand_b = 16'd6; dest_reg = 4'd9;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_wb_en", {31'd0, wb_en}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    run_op(2'd0, 16'd3, 16'd4, 4'd2, 1'b0, rd, rz, rr);
    chk("after_abort", {12'd0, rr, rd}, 32'h2000C);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      a = 16'($urandom);
      if (r[4:2] == 3'd0) b = 16'd0;
      else if (r[5]) b = 16'($urandom_range(1, 255));
      else b = 16'($urandom);
      run_op(r[1:0], a, b, r[11:8], r[6], rd, rz, rr);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
